// File: rtl/inst_rom_responder.sv
// Instruction ROM responder: word reads with a fixed LATENCY pipeline, a loader write port,
// error flagging for misaligned or out-of-range fetches, and a response counter.
module inst_rom_responder #(
    parameter int          DEPTH_LOG2 = 10,
    parameter int          LATENCY    = 1,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_ce,
    input  logic [31:0]           pc,
    output logic [31:0]           inst,
    output logic                  inst_valid,
    output logic                  inst_err,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [31:0]           wr_data,
    output logic [31:0]           fetch_cnt
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("inst_rom_responder: LATENCY must be within 1..4");
    end

    logic [31:0]           mem_q [DEPTH];
    logic [LATENCY-1:0]    vld_q;
    logic [LATENCY-1:0]    err_q;
    logic [31:0]           data_q [LATENCY];
    logic [31:0]           fetch_cnt_q;

    logic                  req_err;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic                  vld_d;
    logic                  err_d;
    logic [31:0]           data_d;

    assign req_err = (pc[1:0] != 2'b00) || (pc[31:DEPTH_LOG2+2] != '0);
    assign req_idx = pc[DEPTH_LOG2+1:2];

    // Stage 1 keeps its word across bubbles so the output holds during gaps.
    always_comb begin
        vld_d  = inst_ce;
        err_d  = inst_ce & req_err;
        data_d = data_q[0];
        if (inst_ce) begin
            if (req_err) data_d = NOP_WORD;
            else         data_d = mem_q[req_idx];
        end
    end

    // Memory is never reset; reading in the same edge as a write returns the old word.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) mem_q[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            err_q <= '0;
            for (int i = 0; i < LATENCY; i++) data_q[i] <= '0;
        end else begin
            vld_q[0]  <= vld_d;
            err_q[0]  <= err_d;
            data_q[0] <= data_d;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i]  <= vld_q[i-1];
                err_q[i]  <= err_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                      fetch_cnt_q <= '0;
        else if (vld_q[LATENCY-1])    fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end

    assign inst       = data_q[LATENCY-1];
    assign inst_valid = vld_q[LATENCY-1];
    assign inst_err   = err_q[LATENCY-1];
    assign fetch_cnt  = fetch_cnt_q;
endmodule

// File: tb/tb_inst_rom_responder.sv
// Bench: three responders (LATENCY 1/3/4) share one stimulus stream and are checked against
// a history-based reference model, a directed vector table and hand-written corner sequences.
module tb_inst_rom_responder;
    localparam int NH = 4096;
    localparam int LAT [3] = '{1, 3, 4};

    logic        clk = 0;
    logic        rst, inst_ce, wr_en;
    logic [31:0] pc, wr_data;
    logic [9:0]  wr_addr;
    logic [31:0] o_inst [3];
    logic        o_vld  [3];
    logic        o_err  [3];
    logic [31:0] o_cnt  [3];

    always #5 clk = ~clk;

    inst_rom_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .inst_ce(inst_ce), .pc(pc), .inst(o_inst[0]), .inst_valid(o_vld[0]),
        .inst_err(o_err[0]), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .fetch_cnt(o_cnt[0]));
    inst_rom_responder #(.DEPTH_LOG2(10), .LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .inst_ce(inst_ce), .pc(pc), .inst(o_inst[1]), .inst_valid(o_vld[1]),
        .inst_err(o_err[1]), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .fetch_cnt(o_cnt[1]));
    inst_rom_responder #(.DEPTH_LOG2(10), .LATENCY(4)) dut4 (
        .clk(clk), .rst(rst), .inst_ce(inst_ce), .pc(pc), .inst(o_inst[2]), .inst_valid(o_vld[2]),
        .inst_err(o_err[2]), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .fetch_cnt(o_cnt[2]));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: per-edge history of what each request produced.
    logic [31:0] mm [1024];
    bit          h_acc [NH];
    bit          h_err [NH];
    logic [31:0] h_last [NH];
    int          n_edge = 0;
    int          last_rst = -1;
    logic [31:0] e_inst [3];
    bit          e_vld [3];
    bit          e_err [3];
    logic [31:0] e_cnt [3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic model_edge();
        logic [31:0] dat;
        bit          bad;
        int          m;
        if (rst) begin
            h_acc[n_edge]  = 0;
            h_err[n_edge]  = 0;
            h_last[n_edge] = 0;
            last_rst = n_edge;
        end else begin
            bad = (pc % 4 != 0) || (pc >= 32'd4096);
            dat = bad ? 32'h0 : mm[pc / 4];
            h_acc[n_edge]  = inst_ce;
            h_err[n_edge]  = bad;
            h_last[n_edge] = inst_ce ? dat : ((n_edge > 0) ? h_last[n_edge-1] : 32'h0);
            if (wr_en) mm[wr_addr] = wr_data;
        end
        for (int j = 0; j < 3; j++) begin
            if (rst)         e_cnt[j] = 0;
            else if (e_vld[j]) e_cnt[j] = e_cnt[j] + 1;
            m = n_edge - LAT[j] + 1;
            if (m < 0 || last_rst >= m) begin
                e_vld[j] = 0; e_err[j] = 0; e_inst[j] = 0;
            end else begin
                e_vld[j]  = h_acc[m];
                e_err[j]  = h_acc[m] & h_err[m];
                e_inst[j] = h_last[m];
            end
        end
        n_edge++;
    endtask

    task automatic model_check();
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("L%0d.valid", LAT[j]), {31'b0, o_vld[j]}, {31'b0, e_vld[j]});
            chk($sformatf("L%0d.err", LAT[j]),   {31'b0, o_err[j]}, {31'b0, e_err[j]});
            chk($sformatf("L%0d.inst", LAT[j]),  o_inst[j], e_inst[j]);
            chk($sformatf("L%0d.cnt", LAT[j]),   o_cnt[j], e_cnt[j]);
        end
    endtask

    task automatic step(input bit r, input bit ce, input logic [31:0] p,
                        input bit we, input logic [9:0] wa, input logic [31:0] wd);
        rst = r; inst_ce = ce; pc = p; wr_en = we; wr_addr = wa; wr_data = wd;
        @(posedge clk);
        model_edge();
        #1;
        model_check();
    endtask

    task automatic idle(); step(0, 0, 0, 0, 0, 0); endtask
    task automatic fetch(input logic [31:0] p); step(0, 1, p, 0, 0, 0); endtask
    task automatic reset1(); step(1, 0, 0, 0, 0, 0); endtask

    typedef struct {
        bit          r; bit ce; logic [31:0] p; bit we; logic [9:0] wa; logic [31:0] wd;
        logic [31:0] x_inst; bit x_vld; bit x_err; logic [31:0] x_cnt;
    } vec_t;

    vec_t vt [12];

    initial begin
        for (int i = 0; i < 1024; i++) mm[i] = 0;
        for (int j = 0; j < 3; j++) begin e_vld[j] = 0; e_cnt[j] = 0; e_inst[j] = 0; e_err[j] = 0; end
        rst = 1; inst_ce = 0; pc = 0; wr_en = 0; wr_addr = 0; wr_data = 0;

        // Initial fill: every word the random phase can reach gets a known value.
        reset1();
        for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 10'(i), 32'hC0DE_0000 | i);

        // Directed table, expectations for the LATENCY=1 responder.
        vt[0]  = '{1, 1, 0,    0, 0, 0,            32'h0,         0, 0, 0};
        vt[1]  = '{1, 1, 4,    1, 3, 32'h1,        32'h0,         0, 0, 0};
        vt[2]  = '{0, 0, 0,    1, 0, 32'h2002_0005, 32'h0,        0, 0, 0};
        vt[3]  = '{0, 0, 0,    1, 1, 32'h2003_000C, 32'h0,        0, 0, 0};
        vt[4]  = '{0, 0, 0,    1, 5, 32'hAAAA_AAAA, 32'h0,        0, 0, 0};
        vt[5]  = '{0, 1, 0,    0, 0, 0,            32'h2002_0005, 1, 0, 0};
        vt[6]  = '{0, 1, 4,    0, 0, 0,            32'h2003_000C, 1, 0, 1};
        vt[7]  = '{0, 1, 6,    0, 0, 0,            32'h0,         1, 1, 2};
        vt[8]  = '{0, 1, 32'h1000, 0, 0, 0,        32'h0,         1, 1, 3};
        vt[9]  = '{0, 1, 20,   1, 5, 32'h5555_5555, 32'hAAAA_AAAA, 1, 0, 4};
        vt[10] = '{0, 1, 20,   0, 0, 0,            32'h5555_5555, 1, 0, 5};
        vt[11] = '{0, 0, 0,    0, 0, 0,            32'h5555_5555, 0, 0, 6};
        for (int i = 0; i < 12; i++) begin
            step(vt[i].r, vt[i].ce, vt[i].p, vt[i].we, vt[i].wa, vt[i].wd);
            chk($sformatf("vec%0d.inst", i),  o_inst[0], vt[i].x_inst);
            chk($sformatf("vec%0d.valid", i), {31'b0, o_vld[0]}, {31'b0, vt[i].x_vld});
            chk($sformatf("vec%0d.err", i),   {31'b0, o_err[0]}, {31'b0, vt[i].x_err});
            chk($sformatf("vec%0d.cnt", i),   o_cnt[0], vt[i].x_cnt);
        end

        // LATENCY=3: requests on edges 1..3, responses after edges 3..5, count 3 after edge 6.
        reset1();
        fetch(0); fetch(4);
        chk("L3.early", {31'b0, o_vld[1]}, 32'd0);
        fetch(8);
        chk("L3.r0.valid", {31'b0, o_vld[1]}, 32'd1); chk("L3.r0.inst", o_inst[1], 32'h2002_0005);
        idle();
        chk("L3.r1.valid", {31'b0, o_vld[1]}, 32'd1); chk("L3.r1.inst", o_inst[1], 32'h2003_000C);
        idle();
        chk("L3.r2.valid", {31'b0, o_vld[1]}, 32'd1); chk("L3.r2.inst", o_inst[1], 32'hC0DE_0002);
        idle();
        chk("L3.cnt", o_cnt[1], 32'd3); chk("L3.after", {31'b0, o_vld[1]}, 32'd0);

        // LATENCY=4: bubble pattern, then reset with three requests in flight.
        reset1();
        fetch(0); idle(); fetch(4);
        chk("L4.pre", {31'b0, o_vld[2]}, 32'd0);
        idle();
        chk("L4.b0", {31'b0, o_vld[2]}, 32'd1);
        idle();
        chk("L4.b1", {31'b0, o_vld[2]}, 32'd0); chk("L4.hold", o_inst[2], 32'h2002_0005);
        fetch(8);
        chk("L4.b2", {31'b0, o_vld[2]}, 32'd1); chk("L4.b2.inst", o_inst[2], 32'h2003_000C);
        fetch(12); fetch(16);
        reset1();
        for (int i = 0; i < 6; i++) begin
            chk("L4.flush.valid", {31'b0, o_vld[2]}, 32'd0);
            chk("L4.flush.inst", o_inst[2], 32'd0);
            chk("L4.flush.cnt", o_cnt[2], 32'd0);
            idle();
        end
        fetch(0); idle(); idle(); idle();
        chk("L4.keep.inst", o_inst[2], 32'h2002_0005); chk("L4.keep.valid", {31'b0, o_vld[2]}, 32'd1);

        // Counter wrap.
        idle(); idle(); idle(); idle();
        force dut1.fetch_cnt_q = 32'hFFFF_FFFE;
        force dut3.fetch_cnt_q = 32'hFFFF_FFFE;
        force dut4.fetch_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut1.fetch_cnt_q;
        release dut3.fetch_cnt_q;
        release dut4.fetch_cnt_q;
        for (int j = 0; j < 3; j++) e_cnt[j] = 32'hFFFF_FFFE;
        fetch(0); fetch(4);
        chk("wrap.0", o_cnt[0], 32'hFFFF_FFFF);
        fetch(8);
        chk("wrap.1", o_cnt[0], 32'h0);
        idle();
        chk("wrap.2", o_cnt[0], 32'h1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            int unsigned sel, w;
            logic [31:0] p;
            sel = $urandom_range(0, 7);
            w   = $urandom_range(0, 15);
            if (sel < 6)       p = w * 4;
            else if (sel == 6) p = w * 4 + $urandom_range(1, 3);
            else               p = $urandom() | 32'h0000_1000;
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), p,
                 ($urandom_range(0, 3) == 0), 10'($urandom_range(0, 15)), $urandom());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
